// File: rtl/sar_search_16bit.sv
// Successive-approximation search controller: drives the probe operand of an
// external comparator MSB first and rebuilds the unknown target from its flags.
module sar_search_16bit #(
   parameter int bit_size = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                gt_in,
   input  logic                eq_in,
   input  logic                lt_in,
   output logic [bit_size:0]   probe,
   output logic                busy,
   output logic                done,
   output logic                found,
   output logic [bit_size:0]   result
);

   localparam int W  = bit_size + 1;
   localparam int IW = $clog2(W);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      COMPARE = 1'b1
   } state_t;

   state_t          state_r, next_state_s;
   logic [W-1:0]    acc_r, acc_next_s, acc_upd_s;
   logic [IW-1:0]   idx_r, idx_next_s;
   logic [W-1:0]    probe_r, probe_next_s;
   logic [W-1:0]    result_r, result_next_s;
   logic            found_r, found_next_s;
   logic            done_r, done_next_s;
   logic            busy_r;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               next_state_s = COMPARE;
            end else begin
               next_state_s = IDLE;
            end
         end
         COMPARE: begin
            if (eq_in || (idx_r == {IW{1'b0}})) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = COMPARE;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Datapath and output next values; lt_in is implied by the absence of eq/gt
   always_comb begin
      acc_next_s    = acc_r;
      idx_next_s    = idx_r;
      probe_next_s  = probe_r;
      result_next_s = result_r;
      found_next_s  = found_r;
      done_next_s   = 1'b0;
      acc_upd_s     = gt_in ? acc_r : probe_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               acc_next_s   = {W{1'b0}};
               idx_next_s   = IW'(bit_size);
               probe_next_s = {1'b1, {(W-1){1'b0}}};
               found_next_s = 1'b0;
            end else begin
               acc_next_s   = acc_r;
            end
         end
         COMPARE: begin
            if (eq_in) begin
               result_next_s = probe_r;
               found_next_s  = 1'b1;
               done_next_s   = 1'b1;
            end else if (idx_r == {IW{1'b0}}) begin
               acc_next_s    = acc_upd_s;
               result_next_s = acc_upd_s;
               found_next_s  = 1'b0;
               done_next_s   = 1'b1;
            end else begin
               acc_next_s    = acc_upd_s;
               idx_next_s    = idx_r - {{(IW-1){1'b0}}, 1'b1};
               probe_next_s  = acc_upd_s | ({{(W-1){1'b0}}, 1'b1} << (idx_r - {{(IW-1){1'b0}}, 1'b1}));
            end
         end
         default: begin
            done_next_s = 1'b0;
         end
      endcase
   end

   // Registered datapath and outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_r    <= {W{1'b0}};
         idx_r    <= {IW{1'b0}};
         probe_r  <= {W{1'b0}};
         result_r <= {W{1'b0}};
         found_r  <= 1'b0;
         done_r   <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         acc_r    <= acc_next_s;
         idx_r    <= idx_next_s;
         probe_r  <= probe_next_s;
         result_r <= result_next_s;
         found_r  <= found_next_s;
         done_r   <= done_next_s;
         busy_r   <= (next_state_s == COMPARE);
      end
   end

   assign probe  = probe_r;
   assign busy   = busy_r;
   assign done   = done_r;
   assign found  = found_r;
   assign result = result_r;

endmodule

// File: tb/tb_sar_search_16bit.sv
// Directed bench for sar_search_16bit with a behavioural comparator in the loop.
module tb_sar_search_16bit;

   logic        clk = 1'b0;
   logic        rst, start;
   logic        gt_in, eq_in, lt_in;
   logic [15:0] probe, result;
   logic        busy, done, found;

   logic [15:0] target;
   int          force_mode;
   int          total = 0;
   int          bad   = 0;

   sar_search_16bit dut (
      .clk(clk), .rst(rst), .start(start),
      .gt_in(gt_in), .eq_in(eq_in), .lt_in(lt_in),
      .probe(probe), .busy(busy), .done(done), .found(found), .result(result)
   );

   always #5 clk = ~clk;

   // Comparator model, with overrides for the forced-flag cases
   always_comb begin
      gt_in = 1'b0;
      eq_in = 1'b0;
      lt_in = 1'b0;
      if (force_mode == 1) begin
         gt_in = 1'b1;
         eq_in = 1'b1;
      end else if (force_mode == 2) begin
         gt_in = 1'b0;
      end else begin
         gt_in = probe > target;
         eq_in = probe == target;
         lt_in = probe < target;
      end
   end

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Count compare edges until done; optionally check the MSB-walk probe sequence
   task automatic wait_done(input int exp_n, input bit chk_seq);
      int n;
      n = 0;
      while (!done && n < 40) begin
         if (chk_seq) check_val("probe_seq", probe, 16'h8000 >> n);
         step();
         n++;
      end
      if (!done) check_val("timeout", 16'd1, 16'd0);
      check_val("compares", 16'(n), 16'(exp_n));
   endtask

   task automatic run_search(input logic [15:0] tgt, input logic [15:0] exp_res,
                             input logic exp_found, input int exp_n, input bit chk_seq);
      target = tgt;
      start  = 1'b1;
      step();
      start  = 1'b0;
      check_val("first_probe", probe, 16'h8000);
      check_val("busy_rise", {15'd0, busy}, 16'd1);
      check_val("found_clr", {15'd0, found}, 16'd0);
      wait_done(exp_n, chk_seq);
      check_val("busy_fall", {15'd0, busy}, 16'd0);
      check_val("found", {15'd0, found}, {15'd0, exp_found});
      check_val("result", result, exp_res);
      step();
      check_val("done_pulse", {15'd0, done}, 16'd0);
      check_val("result_hold", result, exp_res);
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      target     = 16'h0000;
      force_mode = 0;
      step();
      step();
      rst = 1'b0;
      check_val("rst_probe", probe, 16'h0000);
      check_val("rst_busy", {15'd0, busy}, 16'd0);
      check_val("rst_done", {15'd0, done}, 16'd0);
      check_val("rst_found", {15'd0, found}, 16'd0);
      check_val("rst_result", result, 16'h0000);
      step();
      check_val("idle_hold", {15'd0, busy}, 16'd0);

      run_search(16'h8000, 16'h8000, 1'b1, 1, 1'b0);
      run_search(16'h0000, 16'h0000, 1'b0, 16, 1'b1);
      check_val("probe_hold", probe, 16'h0001);
      run_search(16'hFFFF, 16'hFFFF, 1'b1, 16, 1'b0);
      run_search(16'h1234, 16'h1234, 1'b1, 14, 1'b0);
      check_val("probe_hold2", probe, 16'h1234);

      // Reset during the fifth compare of a search for 0x00FF
      target = 16'h00FF;
      start  = 1'b1;
      step();
      start  = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check_val("pre_rst_probe", probe, 16'h0800);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_val("abort_probe", probe, 16'h0000);
      check_val("abort_busy", {15'd0, busy}, 16'd0);
      check_val("abort_found", {15'd0, found}, 16'd0);
      check_val("abort_result", result, 16'h0000);
      for (int i = 0; i < 20; i++) begin
         if (done) check_val("abort_no_done", 16'd1, 16'd0);
         step();
      end
      check_val("abort_done", {15'd0, done}, 16'd0);
      run_search(16'h00FF, 16'h00FF, 1'b0 | 1'b1, 16, 1'b0);

      // start held high throughout
      target = 16'h1234;
      start  = 1'b1;
      step();
      wait_done(14, 1'b0);
      check_val("held_result", result, 16'h1234);
      step();
      check_val("restart_busy", {15'd0, busy}, 16'd1);
      check_val("restart_done", {15'd0, done}, 16'd0);
      check_val("restart_probe", probe, 16'h8000);
      check_val("restart_found", {15'd0, found}, 16'd0);
      start = 1'b0;
      wait_done(14, 1'b0);
      step();

      // Forced flags: eq+gt together, then no flags at all
      force_mode = 1;
      run_search(16'h0000, 16'h8000, 1'b1, 1, 1'b0);
      force_mode = 2;
      run_search(16'h0000, 16'hFFFF, 1'b0, 16, 1'b0);
      force_mode = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sar_search_16bit.md
# sar_search_16bit

Successive-approximation search controller that drives the probe operand of an external `comparator_16bit` and consumes its `gt_out`/`eq_out`/`lt_out` flags to recover an unknown target value held on the comparator's other input. It issues one probe per clock, MSB first, and terminates early on equality. It sits beside the comparator as its sequential initiator: the comparator answers, and this block asks.

## Interface
- `bit_size`, 15, MSB index; all data paths are `bit_size+1` bits wide.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  begin a search; sampled only in IDLE.
- `gt_in`  in  1  comparator result: probe > target.
- `eq_in`  in  1  comparator result: probe == target.
- `lt_in`  in  1  comparator result: probe < target.
- `probe`  out  `bit_size+1`  registered trial value, wired to comparator operand `a`.
- `busy`  out  1  high while the search is in COMPARE.
- `done`  out  1  one-cycle pulse when a search completes.
- `found`  out  1  high if equality was seen; valid from `done` until the next accepted `start`.
- `result`  out  `bit_size+1`  search result; held from `done` until the next accepted `start`.

## Operation
- States: IDLE, COMPARE. Internal registers: `acc` (bits confirmed so far) and `idx` (bit under test, 0..`bit_size`).
- IDLE with `start`=1: `acc`<=0, `idx`<=`bit_size`, `probe`<=1<<`bit_size`, `found`<=0, go to COMPARE.
- IDLE with `start`=0: hold all outputs.
- COMPARE samples the flags once per edge against the current `probe`. Flag priority is eq > gt > lt.
  - `eq_in`: `result`<=`probe`, `found`<=1, `done`<=1, go to IDLE.
  - `gt_in`: bit `idx` is rejected; `acc` is unchanged.
  - Otherwise (`lt_in`, or no flag asserted): bit `idx` is kept; `acc`<=`probe`.
  - Not eq and `idx`==0: `result`<=updated `acc`, `found`<=0, `done`<=1, go to IDLE.
  - Not eq and `idx`>0: `idx`<=`idx`-1, `probe`<=updated `acc` | (1<<(`idx`-1)).
- `start` asserted during COMPARE is ignored; there is no queueing.
- `done` is high only in the first IDLE cycle after completion.
- `start` in that same `done` cycle is accepted normally.
- `found`=0 occurs only when the target was never probed exactly. Because the probe always has its bit under test set, this happens only for target 0. `result` still equals the target in that case.
- All arithmetic is unsigned and within `bit_size+1` bits. No carries or wraps occur.

## Timing
- Reset values: `probe`=0, `busy`=0, `done`=0, `found`=0, `result`=0, state IDLE, `acc`=0, `idx`=0.
- `rst` mid-search aborts in the same edge and returns to reset values. No `done` is produced.
- `start` is accepted at edge E0. The first probe is valid in the cycle after E0, and `busy` rises with it.
- The comparator is combinational. Flags for a probe are sampled at the end of the cycle in which that probe is held, giving one bit per cycle.
- Worst-case latency is `bit_size+1` compare edges (16 for the default width). `done` is high in the cycle after the last compare edge, so search k finishes with `done` at cycle E0+k+1.
- An early exit at compare n (1-based) gives `done` at cycle E0+n+1.
- `busy` falls in the same cycle that `done` rises.
- `probe` holds its last value after completion until the next accepted `start`.

## Test plan
- Target 0x8000, `start` pulse: probe 0x8000, eq on the first compare; `done` 2 cycles after `start`, `found`=1, `result`=0x8000.
- Target 0x0000: probes are 0x8000, 0x4000, …, 0x0001, all gt; `done` after 16 compares, `found`=0, `result`=0x0000.
- Target 0xFFFF: probes are 0x8000, 0xC000, …, 0xFFFF, with eq on the 16th; `found`=1, `result`=0xFFFF. Target 0x1234: eq on the 14th compare (probe 0x1234); `found`=1.
- `rst` pulse at compare 5 of a search for 0x00FF: all outputs return to 0 and no `done` appears. A new `start` then completes normally with `result`=0x00FF.
- `start` held high throughout: pulses during COMPARE are ignored. `start` in the `done` cycle launches an immediate new search, so `busy` is high the next cycle and `done` falls.
- Forced flags with `eq_in` and `gt_in` both high on the first probe: eq wins, so `result`=0x8000 and `found`=1. With no flags asserted for all compares, every bit is kept and `result`=0xFFFF with `found`=0.
